puf_response_shifter: RTL and testbench

Parametrised serial-to-parallel collector for RO-PUF response bits: accepts one comparator bit per valid/ready beat, packs WIDTH bits into a word in a selectable bit order, and presents the word on a valid/ready output port. Sits between the ring-oscillator counter comparator and the response/UART framing logic. It is the next generation of the team's fixed 8-bit shifter, adding width, bit-order mode, backpressure, flush and optional double buffering.

---
 rtl/puf_response_shifter.sv | 134 +++++++++++++
 tb/tb_puf_response_shifter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/puf_response_shifter.sv
// Serial-to-parallel collector for RO-PUF response bits with selectable bit order and valid/ready output.
// Optional double buffering (hold register + PENDING state) is enabled by defining PUF_SHIFT_DUAL_BUF_EN.
module puf_response_shifter #(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_bit,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             msb_first,
  input  logic             flush,
  output logic [WIDTH-1:0] out_word,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] bit_count
);

`ifdef PUF_SHIFT_DUAL_BUF_EN
  typedef enum logic [1:0] {COLLECT, PRESENT, PENDING} state_t;
`else
  typedef enum logic {COLLECT, PRESENT} state_t;
`endif

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_sreg;
  logic [CNT_W-1:0]   r_bit_count;
  logic               r_order;
  logic [WIDTH-1:0]   r_out_word;
  logic [WIDTH-1:0]   w_out_word_nxt;
  logic               w_accept;
  logic               w_complete;
  logic               w_take;
  logic               w_order;
  logic [WIDTH-1:0]   w_shift;
`ifdef PUF_SHIFT_DUAL_BUF_EN
  logic [WIDTH-1:0]   r_hold;
  logic [WIDTH-1:0]   w_hold_nxt;
`endif

`ifdef PUF_SHIFT_DUAL_BUF_EN
  assign in_ready = (r_state != PENDING);
`else
  assign in_ready = (r_state == COLLECT);
`endif
  assign out_valid = (r_state != COLLECT);
  assign out_word  = r_out_word;
  assign bit_count = r_bit_count;

  assign w_accept   = in_valid && in_ready && !flush;
  assign w_complete = w_accept && (r_bit_count == CNT_W'(WIDTH - 1));
  assign w_take     = out_valid && out_ready;
  // The first bit of a word uses msb_first live; later bits use the latched order.
  assign w_order    = (r_bit_count == '0) ? msb_first : r_order;
  assign w_shift    = w_order ? {r_sreg[WIDTH-2:0], in_bit} : {in_bit, r_sreg[WIDTH-1:1]};

  always_comb begin
    w_state_nxt    = r_state;
    w_out_word_nxt = r_out_word;
`ifdef PUF_SHIFT_DUAL_BUF_EN
    w_hold_nxt     = r_hold;
`endif
    case (r_state)
      COLLECT: begin
        if (w_complete) begin
          w_out_word_nxt = w_shift;
          w_state_nxt    = PRESENT;
        end
      end
      PRESENT: begin
        if (w_complete && w_take) begin
          w_out_word_nxt = w_shift;
`ifdef PUF_SHIFT_DUAL_BUF_EN
        end else if (w_complete) begin
          w_hold_nxt  = w_shift;
          w_state_nxt = PENDING;
`endif
        end else if (w_take) begin
          w_state_nxt = COLLECT;
        end
      end
`ifdef PUF_SHIFT_DUAL_BUF_EN
      PENDING: begin
        if (w_take) begin
          w_out_word_nxt = r_hold;
          w_state_nxt    = PRESENT;
        end
      end
`endif
      default: w_state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= COLLECT;
      r_out_word <= '0;
`ifdef PUF_SHIFT_DUAL_BUF_EN
      r_hold     <= '0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_out_word <= w_out_word_nxt;
`ifdef PUF_SHIFT_DUAL_BUF_EN
      r_hold     <= w_hold_nxt;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sreg      <= '0;
      r_bit_count <= '0;
      r_order     <= 1'b0;
    end else if (flush) begin
      r_sreg      <= '0;
      r_bit_count <= '0;
    end else if (w_accept) begin
      if (r_bit_count == '0) begin
        r_order <= msb_first;
      end
      if (w_complete) begin
        r_sreg      <= '0;
        r_bit_count <= '0;
      end else begin
        r_sreg      <= w_shift;
        r_bit_count <= r_bit_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_puf_response_shifter.sv
// Randomised and directed self-checking bench for puf_response_shifter against a queue-based word model.
module tb_puf_response_shifter;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
`ifdef PUF_SHIFT_DUAL_BUF_EN
  localparam int unsigned CAP = 2;
`else
  localparam int unsigned CAP = 1;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_bit = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             msb_first = 1'b1;
  logic             flush = 1'b0;
  logic [WIDTH-1:0] out_word;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [CNT_W-1:0] bit_count;

  int n_cmp = 0;
  int n_err = 0;

  // Model: bits of the partial word in arrival order, and completed words awaiting handshake.
  logic             m_bits[$];
  logic [WIDTH-1:0] m_words[$];
  logic             m_order = 1'b0;
  logic [WIDTH-1:0] m_word = '0;

  puf_response_shifter #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .in_bit(in_bit), .in_valid(in_valid), .in_ready(in_ready),
    .msb_first(msb_first), .flush(flush), .out_word(out_word), .out_valid(out_valid),
    .out_ready(out_ready), .bit_count(bit_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input logic v, input logic b, input logic m, input logic f,
                            input logic o, input logic r);
    logic acc, take;
    logic [WIDTH-1:0] w;
    acc  = v && (m_words.size() < CAP) && !f;
    take = (m_words.size() > 0) && o;
    if (r) begin
      m_bits.delete();
      m_words.delete();
      m_order = 1'b0;
      m_word  = '0;
    end else begin
      if (take) void'(m_words.pop_front());
      if (f) begin
        m_bits.delete();
      end else if (acc) begin
        if (m_bits.size() == 0) m_order = m;
        m_bits.push_back(b);
        if (m_bits.size() == WIDTH) begin
          w = '0;
          for (int i = 0; i < int'(WIDTH); i++) begin
            if (m_bits[i])
              w = w + ({{(WIDTH-1){1'b0}}, 1'b1} << (m_order ? (WIDTH - 1 - i) : i));
          end
          m_words.push_back(w);
          m_bits.delete();
        end
      end
      if (m_words.size() > 0) m_word = m_words[0];
    end
  endtask

  task automatic step(input logic v, input logic b, input logic m, input logic f,
                      input logic o, input logic r);
    in_valid = v; in_bit = b; msb_first = m; flush = f; out_ready = o; rst = r;
    @(posedge clk);
    model_edge(v, b, m, f, o, r);
    #1;
    check("out_valid", 64'(out_valid), 64'(m_words.size() > 0));
    check("in_ready", 64'(in_ready), 64'(m_words.size() < CAP));
    check("bit_count", 64'(bit_count), 64'(m_bits.size()));
    check("out_word", 64'(out_word), 64'(m_word));
  endtask

  task automatic idle(input logic o);
    step(1'b0, 1'b0, 1'b1, 1'b0, o, 1'b0);
  endtask

  // Presents pattern[7] first, pattern[0] last.
  task automatic send8(input logic [7:0] pattern, input logic m, input logic o);
    for (int i = 7; i >= 0; i--) step(1'b1, pattern[i], m, 1'b0, o, 1'b0);
  endtask

  initial begin
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    check("rst_word", 64'(out_word), 64'h0);
    check("rst_valid", 64'(out_valid), 64'h0);
    check("rst_ready", 64'(in_ready), 64'h1);
    check("rst_count", 64'(bit_count), 64'h0);

    // MSB-first word with consumer always ready
    send8(8'b1011_0010, 1'b1, 1'b1);
    check("msb_word", 64'(out_word), 64'hB2);
    check("msb_valid", 64'(out_valid), 64'h1);
    check("msb_count", 64'(bit_count), 64'h0);
    idle(1'b1);
    check("msb_valid_drop", 64'(out_valid), 64'h0);

    // LSB-first word, order toggled after the third bit
    for (int i = 0; i < 8; i++) begin
      logic [7:0] pat;
      pat = 8'b1011_0010;
      step(1'b1, pat[7-i], (i < 3) ? 1'b0 : 1'b1, 1'b0, 1'b1, 1'b0);
    end
    check("lsb_word", 64'(out_word), 64'h4D);
    idle(1'b1);

    // Backpressure
    send8(8'b1011_0010, 1'b1, 1'b0);
`ifdef PUF_SHIFT_DUAL_BUF_EN
    send8(8'hFF, 1'b1, 1'b0);
    check("bp_pending_ready", 64'(in_ready), 64'h0);
    check("bp_pending_word", 64'(out_word), 64'hB2);
    idle(1'b1);
    check("bp_second_word", 64'(out_word), 64'hFF);
    check("bp_second_valid", 64'(out_valid), 64'h1);
    idle(1'b1);
    check("bp_drained", 64'(out_valid), 64'h0);
`else
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("bp_ready", 64'(in_ready), 64'h0);
    check("bp_word", 64'(out_word), 64'hB2);
    check("bp_count", 64'(bit_count), 64'h0);
    idle(1'b1);
    check("bp_drained", 64'(out_valid), 64'h0);
`endif

    // Flush coincident with a fourth bit
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    check("flush_count", 64'(bit_count), 64'h0);
    send8(8'hA5, 1'b1, 1'b1);
    check("flush_word", 64'(out_word), 64'hA5);
    idle(1'b1);

    // Word completes in the handshake cycle
    send8(8'h0F, 1'b1, 1'b0);
`ifdef PUF_SHIFT_DUAL_BUF_EN
    for (int i = 7; i >= 1; i--) step(1'b1, (i >= 4) ? 1'b1 : 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("b2b_valid", 64'(out_valid), 64'h1);
    check("b2b_word", 64'(out_word), 64'hF0);
`else
    check("b2b_word", 64'(out_word), 64'h0F);
`endif
    idle(1'b1);

    // Reset with a word presented and a partial word
`ifdef PUF_SHIFT_DUAL_BUF_EN
    send8(8'h0F, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("pre_rst_count", 64'(bit_count), 64'h5);
    check("pre_rst_valid", 64'(out_valid), 64'h1);
`else
    send8(8'h0F, 1'b1, 1'b0);
    check("pre_rst_valid", 64'(out_valid), 64'h1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("pre_rst_count", 64'(bit_count), 64'h5);
`endif
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    check("mid_rst_word", 64'(out_word), 64'h0);
    check("mid_rst_valid", 64'(out_valid), 64'h0);
    check("mid_rst_count", 64'(bit_count), 64'h0);
    check("mid_rst_ready", 64'(in_ready), 64'h1);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, 1'($urandom), 1'($urandom),
           ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0, 1'($urandom),
           ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
